// File: rtl/adc_wave_capture.sv
// Triggered ADC burst capture into on-chip RAM, with indexed sample / status read-back
// for the CPU's parallel I/O.
module adc_wave_capture #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              trig_in,
    input  logic [7:0]        adc_control,
    input  logic [15:0]       samplenum,
    output logic [DATA_W-1:0] wavesample,
    output logic              capture_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [15:0]     DEPTH16 = 16'(DEPTH);
    localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_e;

    state_e            state_q;
    logic [ADDR_W:0]   wr_cnt_q;
    logic [3:0]        ctrl_q, ctrl_prev_q;
    logic [15:0]       samp_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic arm_rise, soft_rise, clear, trig, we;
    logic [DATA_W-1:0] status;
    logic unused_ctrl;

    assign unused_ctrl = ^adc_control[7:4];
    assign arm_rise    = ctrl_q[0] & ~ctrl_prev_q[0];
    assign soft_rise   = ctrl_q[1] & ~ctrl_prev_q[1];
    assign clear       = ctrl_q[3];
    assign trig        = soft_rise | (trig_in & ctrl_q[2]);
    assign we          = !reset && !clear && (state_q == CAPTURE) && adc_valid;

    always_comb begin
        status                  = '0;
        status[DATA_W-1]        = (state_q == DONE);
        status[DATA_W-2]        = (state_q == CAPTURE);
        status[DATA_W-3]        = (state_q == ARMED);
        status[ADDR_W:0]        = wr_cnt_q;
        rdata_d                 = '0;
        if (samp_q < DEPTH16)
            rdata_d = mem[samp_q[ADDR_W-1:0]];
        else if (samp_q == 16'hFFFF)
            rdata_d = status;
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_cnt_q[ADDR_W-1:0]] <= adc_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            done_q      <= 1'b0;
            samp_q      <= '0;
            rdata_q     <= '0;
            // Prime both history stages so a bit held high across reset is not an edge.
            ctrl_q      <= adc_control[3:0];
            ctrl_prev_q <= adc_control[3:0];
        end else begin
            ctrl_q      <= adc_control[3:0];
            ctrl_prev_q <= ctrl_q;
            samp_q      <= samplenum;
            rdata_q     <= rdata_d;
            done_q      <= 1'b0;
            if (clear) begin
                state_q  <= IDLE;
                wr_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: if (arm_rise) begin
                        state_q  <= ARMED;
                        wr_cnt_q <= '0;
                    end
                    ARMED: if (trig) state_q <= CAPTURE;
                    CAPTURE: if (adc_valid) begin
                        wr_cnt_q <= wr_cnt_q + ONE;
                        if (wr_cnt_q == LAST) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign wavesample   = rdata_q;
    assign capture_done = done_q;

endmodule

// File: tb/tb_adc_wave_capture.sv
// Directed bench for adc_wave_capture: read-back table after a full capture plus
// hand-written sequences for trigger, clear, reset and arm corner cases.
module tb_adc_wave_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        trig_in;
    logic [7:0]  adc_control;
    logic [15:0] samplenum;
    logic [15:0] wavesample;
    logic        capture_done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    adc_wave_capture #(.DATA_W(16), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
        .trig_in(trig_in), .adc_control(adc_control), .samplenum(samplenum),
        .wavesample(wavesample), .capture_done(capture_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!reset && capture_done) done_cnt++;

    typedef struct {
        string       name;
        logic [15:0] idx;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
        end
    endtask

    task automatic ctrl(input logic [7:0] v);
        adc_control = v;
        step();
    endtask

    task automatic rd(input logic [15:0] idx, output logic [15:0] v);
        samplenum = idx;
        step();
        step();
        v = wavesample;
    endtask

    task automatic feed(input int n, input logic [15:0] base);
        adc_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            adc_data = base + 16'(i);
            step();
        end
        adc_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        tbl[0] = '{"rd_idx0",    16'h0000, 16'h0000};
        tbl[1] = '{"rd_idx5",    16'h0005, 16'h0005};
        tbl[2] = '{"rd_idx1023", 16'h03FF, 16'h03FF};
        tbl[3] = '{"rd_idx512",  16'h0200, 16'h0200};
        tbl[4] = '{"status_done",16'hFFFF, 16'h8400};
        tbl[5] = '{"rd_0400",    16'h0400, 16'h0000};
        tbl[6] = '{"rd_8000",    16'h8000, 16'h0000};
        tbl[7] = '{"rd_FFFE",    16'hFFFE, 16'h0000};

        reset = 1'b1; adc_data = '0; adc_valid = 1'b0; trig_in = 1'b0;
        adc_control = 8'h01; samplenum = 16'hFFFF;
        step(); step(); step();
        chk("reset_wavesample", wavesample, 16'h0000);
        chk("reset_done", {15'b0, capture_done}, 16'h0000);
        reset = 1'b0;
        step(); step();
        rd(16'hFFFF, v);
        chk("arm_held_thru_reset_idle", v, 16'h0000);

        // Full capture: arm, soft trigger, 1024 samples 0..1023.
        ctrl(8'h00); ctrl(8'h00);
        ctrl(8'h01); ctrl(8'h01); ctrl(8'h01);
        ctrl(8'h03); ctrl(8'h03); ctrl(8'h03);
        rd(16'hFFFF, v);
        chk("status_capture_start", v, 16'h4000);
        feed(1024, 16'h0000);
        chk("done_pulse_after_last", {15'b0, capture_done}, 16'h0001);
        step();
        chk("done_pulse_one_cycle", {15'b0, capture_done}, 16'h0000);
        chk("done_count", 16'(done_cnt), 16'h0001);
        for (int i = 0; i < 8; i++) begin
            rd(tbl[i].idx, v);
            chk(tbl[i].name, v, tbl[i].exp);
        end

        // Rearm from DONE; external trigger gated by enable bit.
        ctrl(8'h00); ctrl(8'h00);
        ctrl(8'h01); ctrl(8'h01); ctrl(8'h01);
        rd(16'hFFFF, v);
        chk("rearm_from_done", v, 16'h2000);
        trig_in = 1'b1; step(); trig_in = 1'b0; step(); step();
        rd(16'hFFFF, v);
        chk("ext_trig_disabled", v, 16'h2000);
        ctrl(8'h05); ctrl(8'h05);
        trig_in = 1'b1; step(); trig_in = 1'b0; step(); step();
        for (int i = 0; i < 20; i++) begin
            adc_valid = (i % 2 == 0);
            adc_data  = 16'(100 + i);
            step();
        end
        adc_valid = 1'b0;
        rd(16'hFFFF, v);
        chk("status_gated_10", v, 16'h400A);
        rd(16'h0000, v);
        chk("gated_first_sample", v, 16'h0064);
        rd(16'h0009, v);
        chk("gated_tenth_sample", v, 16'h0076);

        // Clear at wr_cnt=300.
        feed(290, 16'hA000);
        rd(16'hFFFF, v);
        chk("status_300_pre_clear", v, 16'h412C);
        ctrl(8'h0D); step();
        rd(16'hFFFF, v);
        chk("status_after_clear", v, 16'h0000);
        rd(16'h0000, v);
        chk("ram_kept_after_clear", v, 16'h0064);
        rd(16'h000A, v);
        chk("ram_kept_idx10", v, 16'hA000);
        ctrl(8'h00); ctrl(8'h00);

        // Reset at wr_cnt=300.
        ctrl(8'h01); ctrl(8'h01); ctrl(8'h01);
        ctrl(8'h03); ctrl(8'h03); ctrl(8'h03);
        feed(300, 16'hB000);
        rd(16'hFFFF, v);
        chk("status_300_pre_reset", v, 16'h412C);
        reset = 1'b1; step(); reset = 1'b0; step();
        rd(16'hFFFF, v);
        chk("status_after_reset", v, 16'h0000);
        rd(16'h0000, v);
        chk("ram_kept_after_reset", v, 16'hB000);

        // Arm and soft trigger rising together: trigger ignored.
        ctrl(8'h00); ctrl(8'h00);
        ctrl(8'h03); ctrl(8'h03); ctrl(8'h03);
        rd(16'hFFFF, v);
        chk("arm_trig_same_cycle", v, 16'h2000);
        ctrl(8'h01); ctrl(8'h01);
        ctrl(8'h03); ctrl(8'h03); ctrl(8'h03);
        rd(16'hFFFF, v);
        chk("second_trig_capture", v, 16'h4000);

        // Clear beats a simultaneous arm edge.
        ctrl(8'h00); ctrl(8'h08); ctrl(8'h08);
        ctrl(8'h09); ctrl(8'h09);
        rd(16'hFFFF, v);
        chk("clear_beats_arm", v, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
